// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and types for the ALU issue controller: flag positions,
// flag-mask bit order, ALU op encodings and the EFLAGS reset value.
package alu_issue_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned FMASK_W = 6;

    localparam logic [DATA_W-1:0] EFLAGS_RST_VAL = 32'h0000_0002;

    // Bit positions inside the EFLAGS / ALU flags vector
    localparam int unsigned FLAG_CF    = 0;
    localparam int unsigned FLAG_RSVD1 = 1;
    localparam int unsigned FLAG_PF    = 2;
    localparam int unsigned FLAG_AF    = 4;
    localparam int unsigned FLAG_ZF    = 6;
    localparam int unsigned FLAG_SF    = 7;
    localparam int unsigned FLAG_OF    = 11;

    // Bit positions inside a request flag mask
    localparam int unsigned FM_CF = 0;
    localparam int unsigned FM_PF = 1;
    localparam int unsigned FM_AF = 2;
    localparam int unsigned FM_ZF = 3;
    localparam int unsigned FM_SF = 4;
    localparam int unsigned FM_OF = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_ADC = 3'd5,
        ALU_SBB = 3'd6,
        ALU_CMP = 3'd7
    } alu_op_e;

    typedef struct packed {
        alu_op_e              op;
        logic [FMASK_W-1:0]   fmask;
        logic                 id;
    } issue_ctl_t;

    typedef struct packed {
        logic [FMASK_W-1:0]   fmask;
        logic                 id;
    } rsp_ctl_t;

    // Expand a 6-bit flag mask into a mask over the EFLAGS vector
    function automatic logic [DATA_W-1:0] fmask_to_bits(input logic [FMASK_W-1:0] fmask);
        logic [DATA_W-1:0] m;
        m          = '0;
        m[FLAG_CF] = fmask[FM_CF];
        m[FLAG_PF] = fmask[FM_PF];
        m[FLAG_AF] = fmask[FM_AF];
        m[FLAG_ZF] = fmask[FM_ZF];
        m[FLAG_SF] = fmask[FM_SF];
        m[FLAG_OF] = fmask[FM_OF];
        return m;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_arb.sv
// alu_rr_arb2: two-way round-robin arbiter; the pointer moves only when a
// granted request is actually accepted downstream.
module alu_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic       accept_en,
    output logic [1:0] grant_c,
    output logic       fire_c,
    output logic       win_id_c
);

    logic last_id;

    // A requester is granted if the other is idle or it lost the last transfer
    always_comb begin
        grant_c[0] = !req_valid[1] || last_id;
        grant_c[1] = !req_valid[0] || !last_id;
        win_id_c   = req_valid[1] && grant_c[1];
        fire_c     = accept_en && |(req_valid & grant_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_id <= 1'b1;
        end else if (fire_c) begin
            last_id <= win_id_c;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one combinational ALU between two requesters through a two-stage
// issue/result pipeline and maintains the architectural EFLAGS register.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned  W          = DATA_W,
    parameter logic [W-1:0] EFLAGS_RST = W'(EFLAGS_RST_VAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [W-1:0]       req0_a,
    input  logic [W-1:0]       req0_b,
    input  logic [OP_W-1:0]    req0_op,
    input  logic [FMASK_W-1:0] req0_fmask,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [W-1:0]       req1_a,
    input  logic [W-1:0]       req1_b,
    input  logic [OP_W-1:0]    req1_op,
    input  logic [FMASK_W-1:0] req1_fmask,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    output logic [OP_W-1:0]    alu_op,
    input  logic [W-1:0]       alu_out,
    input  logic [W-1:0]       alu_flags,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [W-1:0]       rsp_result,
    output logic [W-1:0]       rsp_flags,
    input  logic               eflags_wr_en,
    input  logic [W-1:0]       eflags_wr_data,
    output logic [W-1:0]       eflags
);

    localparam logic [W-1:0] RSVD_BIT = W'(1) << FLAG_RSVD1;

    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    issue_ctl_t   s1_ctl;
    rsp_ctl_t     s2_ctl;

    logic         s1_adv_c;
    logic         s2_adv_c;
    logic [1:0]   grant_c;
    logic         fire_c;
    logic         win_id_c;
    logic [W-1:0] flag_mask_c;
    logic [W-1:0] eflags_merged_c;

    assign s2_adv_c = !rsp_valid || rsp_ready;
    assign s1_adv_c = !s1_valid || s2_adv_c;

    alu_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid ({req1_valid, req0_valid}),
        .accept_en (s1_adv_c),
        .grant_c   (grant_c),
        .fire_c    (fire_c),
        .win_id_c  (win_id_c)
    );

    assign req0_ready = grant_c[0] && s1_adv_c;
    assign req1_ready = grant_c[1] && s1_adv_c;

    assign alu_a  = s1_a;
    assign alu_b  = s1_b;
    assign alu_op = s1_ctl.op;
    assign rsp_id = s2_ctl.id;

    // Issue stage: capture the winning request
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ctl   <= '0;
        end else if (s1_adv_c) begin
            s1_valid <= fire_c;
            if (fire_c) begin
                s1_a   <= win_id_c ? req1_a : req0_a;
                s1_b   <= win_id_c ? req1_b : req0_b;
                s1_ctl <= win_id_c ? '{op: alu_op_e'(req1_op), fmask: req1_fmask, id: 1'b1}
                                   : '{op: alu_op_e'(req0_op), fmask: req0_fmask, id: 1'b0};
            end
        end
    end

    // Result stage: holds the response stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            s2_ctl     <= '0;
        end else if (s2_adv_c) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_result <= alu_out;
                rsp_flags  <= alu_flags;
                s2_ctl     <= '{fmask: s1_ctl.fmask, id: s1_ctl.id};
            end
        end
    end

    // Masked merge never touches bit 1, so it stays set
    always_comb begin
        flag_mask_c     = W'(fmask_to_bits(s2_ctl.fmask));
        eflags_merged_c = (eflags & ~flag_mask_c) | (rsp_flags & flag_mask_c);
    end

    // A direct write overrides a coincident response merge
    always_ff @(posedge clk) begin
        if (reset) begin
            eflags <= EFLAGS_RST;
        end else if (eflags_wr_en) begin
            eflags <= eflags_wr_data | RSVD_BIT;
        end else if (rsp_valid && rsp_ready) begin
            eflags <= eflags_merged_c;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: a transaction-level model predicts
// responses, ready and EFLAGS every cycle; directed pins anchor the model.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [5:0]  req0_fmask, req1_fmask;
    logic [31:0] alu_a, alu_b, alu_out, alu_flags;
    logic [2:0]  alu_op;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result, rsp_flags;
    logic        eflags_wr_en;
    logic [31:0] eflags_wr_data, eflags;

    int checks   = 0;
    int failures = 0;

    // Bench ALU: flags come from a fixed formula unless overridden
    logic        ovr_en;
    logic [31:0] ovr_val;

    function automatic logic [31:0] calc_res(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        return (op == 3'd0) ? a + b : a ^ b;
    endfunction

    function automatic logic [31:0] calc_flags(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                                input logic oe, input logic [31:0] ov);
        return oe ? ov : ({a[15:0], b[15:0]} ^ {29'd0, op});
    endfunction

    always_comb begin
        alu_out   = calc_res(alu_a, alu_b, alu_op);
        alu_flags = calc_flags(alu_a, alu_b, alu_op, ovr_en, ovr_val);
    end

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_fmask(req0_fmask),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_fmask(req1_fmask),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .eflags_wr_en(eflags_wr_en), .eflags_wr_data(eflags_wr_data), .eflags(eflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [31:0] flg;
        logic [5:0]  fm;
        int          acc;
    } txn_t;

    txn_t        q[$];
    int          edge_n   = 0;
    int          last_hs  = 0;
    logic        last_win = 1'b1;
    logic [31:0] m_eflags = 32'h2;

    // Flag-mask bit i maps to this EFLAGS bit
    int flag_pos[6] = '{0, 2, 4, 6, 7, 11};

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] flg, input logic [5:0] fm);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 6; i++)
            if (fm[i]) r[flag_pos[i]] = flg[flag_pos[i]];
        return r;
    endfunction

    // Head response is visible one edge after acceptance, and no earlier
    // than the edge that retired its predecessor
    function automatic bit m_rsp_valid();
        int vis;
        if (q.size() == 0) return 1'b0;
        vis = (q[0].acc + 1 > last_hs) ? q[0].acc + 1 : last_hs;
        return edge_n >= vis;
    endfunction

    function automatic bit m_ready(input int n);
        bit grant;
        bit space;
        if (n == 0) grant = !req1_valid || (last_win == 1'b1);
        else        grant = !req0_valid || (last_win == 1'b0);
        space = (q.size() < 2) || rsp_ready;
        return grant && space;
    endfunction

    initial begin : model_proc
        bit   hs, a0, a1;
        txn_t t;
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                last_win = 1'b1;
                m_eflags = 32'h2;
                last_hs  = 0;
            end else begin
                hs = m_rsp_valid() && rsp_ready;
                a0 = req0_valid && m_ready(0);
                a1 = req1_valid && m_ready(1);
                if (eflags_wr_en)  m_eflags = eflags_wr_data | 32'h2;
                else if (hs)       m_eflags = merge(m_eflags, q[0].flg, q[0].fm);
                if (hs) begin
                    void'(q.pop_front());
                    last_hs = edge_n + 1;
                end
                if (a0 || a1) begin
                    t.id  = a1;
                    t.res = a1 ? calc_res(req1_a, req1_b, req1_op) : calc_res(req0_a, req0_b, req0_op);
                    t.flg = a1 ? calc_flags(req1_a, req1_b, req1_op, ovr_en, ovr_val)
                               : calc_flags(req0_a, req0_b, req0_op, ovr_en, ovr_val);
                    t.fm  = a1 ? req1_fmask : req0_fmask;
                    t.acc = edge_n + 1;
                    q.push_back(t);
                    last_win = a1;
                end
            end
            edge_n++;
        end
    end

    // Compare DUT outputs against the model every cycle, mid-period
    initial begin : compare_proc
        bit v;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            v = m_rsp_valid();
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, v});
            check("req0_ready", {31'd0, req0_ready}, {31'd0, m_ready(0)});
            check("req1_ready", {31'd0, req1_ready}, {31'd0, m_ready(1)});
            check("eflags", eflags, m_eflags);
            if (v && rsp_valid) begin
                check("rsp_id", {31'd0, rsp_id}, {31'd0, q[0].id});
                check("rsp_result", rsp_result, q[0].res);
                check("rsp_flags", rsp_flags, q[0].flg);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload();
        req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7)); req0_fmask = 6'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7)); req1_fmask = 6'($urandom);
    endtask

    initial begin : stim_proc
        logic        ids[$];
        logic [31:0] first_exp;
        int          cnt;

        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        eflags_wr_en = 1'b0; eflags_wr_data = '0; ovr_en = 1'b1; ovr_val = 32'h0;
        rand_payload();
        step(); step();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_ready0", {31'd0, req0_ready}, 32'd1);
        check("rst_ready1", {31'd0, req1_ready}, 32'd1);
        check("rst_eflags", eflags, 32'h0000_0002);
        reset = 1'b0;

        // Round robin: both valid for six cycles, no flag updates
        for (int i = 0; i < 10; i++) begin
            rand_payload();
            req0_fmask = 6'd0; req1_fmask = 6'd0;
            req0_valid = (i < 6); req1_valid = (i < 6);
            step();
            if (rsp_valid) ids.push_back(rsp_id);
        end
        check("rr_count", ids.size(), 32'd6);
        for (int i = 0; i < ids.size() && i < 6; i++)
            check("rr_id_seq", {31'd0, ids[i]}, 32'(i % 2));

        // Single add with a fixed flags vector
        ovr_val = 32'h0000_0891;
        req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_op = 3'd0; req0_fmask = 6'h3F;
        step();
        req0_valid = 1'b0;
        step();
        check("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("add_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("add_rsp_result", rsp_result, 32'h8000_0000);
        step();
        check("add_eflags", eflags, 32'h0000_0893);

        // Partial mask: only CF may change
        ovr_val = 32'h0;
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom; req1_op = 3'd0; req1_fmask = 6'b000001;
        step();
        req1_valid = 1'b0;
        step(); step();
        check("partial_eflags", eflags, 32'h0000_0892);

        // Direct write coinciding with a response handshake wins
        ovr_val = 32'hFFFF_FFFF;
        req0_valid = 1'b1; req0_fmask = 6'h3F; req0_op = 3'd0;
        step();
        req0_valid = 1'b0;
        step();
        eflags_wr_en = 1'b1; eflags_wr_data = 32'h0;
        step();
        eflags_wr_en = 1'b0;
        check("wr_wins_eflags", eflags, 32'h0000_0002);

        // Backpressure: two outstanding, first response held
        ovr_en = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            req0_op = 3'd0; req1_op = 3'd0;
            req0_valid = 1'b1; req1_valid = 1'b1;
            if (i == 0) first_exp = req1_a + req1_b;
            step();
            if (i >= 1) check("bp_ready_drop", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_hold_id", {31'd0, rsp_id}, 32'd1);
        check("bp_hold_result", rsp_result, first_exp);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) cnt++;
            step();
        end
        check("bp_drain_count", cnt, 32'd2);

        // Reset with two requests in flight discards them
        rsp_ready = 1'b0;
        rand_payload();
        req0_valid = 1'b1; req1_valid = 1'b1;
        step(); step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check("post_rst_eflags", eflags, 32'h0000_0002);

        // Random traffic, backpressure, direct writes and occasional reset
        for (int i = 0; i < 600; i++) begin
            rand_payload();
            req0_valid     = ($urandom_range(0, 99) < 60);
            req1_valid     = ($urandom_range(0, 99) < 60);
            rsp_ready      = ($urandom_range(0, 99) < 65);
            eflags_wr_en   = ($urandom_range(0, 99) < 4);
            eflags_wr_data = $urandom;
            reset          = ($urandom_range(0, 199) == 0);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        eflags_wr_en = 1'b0; reset = 1'b0;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
